// File: rtl/lsu_arbiter_if.sv
// Request/memory bundle for lsu_arbiter: fetch and execute requesters plus the shared memory port.
interface lsu_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              i_f_req;
    logic [AW-1:0]     i_f_addr;
    logic              o_f_ack;

    logic              i_e_req;
    logic              i_e_we;
    logic [AW-1:0]     i_e_addr;
    logic [DW/8-1:0]   i_e_byte_en;
    logic [DW-1:0]     i_e_wdata;
    logic              o_e_ack;

    logic [DW-1:0]     o_rdata;
    logic              o_wait;

    logic              o_m_req;
    logic              o_m_we;
    logic [AW-1:0]     o_m_addr;
    logic [DW/8-1:0]   o_m_byte_en;
    logic [DW-1:0]     o_m_wdata;
    logic [DW-1:0]     i_m_rdata;
    logic              i_m_ack;

    // Arbiter side
    modport slave (
        input  i_f_req, i_f_addr,
        input  i_e_req, i_e_we, i_e_addr, i_e_byte_en, i_e_wdata,
        input  i_m_rdata, i_m_ack,
        output o_f_ack, o_e_ack, o_rdata, o_wait,
        output o_m_req, o_m_we, o_m_addr, o_m_byte_en, o_m_wdata
    );

    // Requester/memory model side
    modport master (
        output i_f_req, i_f_addr,
        output i_e_req, i_e_we, i_e_addr, i_e_byte_en, i_e_wdata,
        output i_m_rdata, i_m_ack,
        input  o_f_ack, o_e_ack, o_rdata, o_wait,
        input  o_m_req, o_m_we, o_m_addr, o_m_byte_en, o_m_wdata
    );
endinterface

// File: rtl/lsu_arbiter.sv
// Fetch/execute arbiter onto a single memory port, one outstanding transaction at a time.
// Define LSU_ARB_RR_EN for round-robin arbitration; default is execute-over-fetch priority.
module lsu_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    lsu_arbiter_if.slave  bus
);
    localparam int unsigned BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_E = 2'd2
    } state_e;

    state_e          state_q;
    logic            m_req_q;
    logic            m_we_q;
    logic [AW-1:0]   m_addr_q;
    logic [BW-1:0]   m_be_q;
    logic [DW-1:0]   m_wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            f_ack_q;
    logic            e_ack_q;
    logic            grant_e;

`ifdef LSU_ARB_RR_EN
    logic            last_e_q;
    // On a tie the requester that did not win last time gets the port
    assign grant_e = bus.i_e_req && !(bus.i_f_req && last_e_q);
`else
    assign grant_e = bus.i_e_req;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            f_ack_q   <= 1'b0;
            e_ack_q   <= 1'b0;
`ifdef LSU_ARB_RR_EN
            last_e_q  <= 1'b0;
`endif
        end else if (i_clk_en) begin
            f_ack_q <= 1'b0;
            e_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_e) begin
                        state_q   <= BUSY_E;
                        m_req_q   <= 1'b1;
                        m_we_q    <= bus.i_e_we;
                        m_addr_q  <= bus.i_e_addr;
                        m_be_q    <= bus.i_e_byte_en;
                        m_wdata_q <= bus.i_e_wdata;
`ifdef LSU_ARB_RR_EN
                        last_e_q  <= 1'b1;
`endif
                    end else if (bus.i_f_req) begin
                        state_q   <= BUSY_F;
                        m_req_q   <= 1'b1;
                        m_we_q    <= 1'b0;
                        m_addr_q  <= bus.i_f_addr;
                        m_be_q    <= '1;
                        m_wdata_q <= '0;
`ifdef LSU_ARB_RR_EN
                        last_e_q  <= 1'b0;
`endif
                    end
                end
                BUSY_F, BUSY_E: begin
                    if (bus.i_m_ack) begin
                        state_q <= IDLE;
                        m_req_q <= 1'b0;
                        if (!m_we_q) begin
                            rdata_q <= bus.i_m_rdata;
                        end
                        f_ack_q <= (state_q == BUSY_F);
                        e_ack_q <= (state_q == BUSY_E);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_f_ack     = f_ack_q;
    assign bus.o_e_ack     = e_ack_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_wait      = bus.i_e_req && !e_ack_q;
    assign bus.o_m_req     = m_req_q;
    assign bus.o_m_we      = m_we_q;
    assign bus.o_m_addr    = m_addr_q;
    assign bus.o_m_byte_en = m_be_q;
    assign bus.o_m_wdata   = m_wdata_q;
endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: table of single transactions plus hand-written corner sequences.
module tb_lsu_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    always #5 clk = ~clk;

    lsu_arbiter_if #(.AW(32), .DW(32)) bus ();

    lsu_arbiter #(.AW(32), .DW(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .bus      (bus)
    );

    typedef struct {
        logic        f_req;
        logic        e_req;
        logic        e_we;
        logic [31:0] f_addr;
        logic [31:0] e_addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] m_rdata;
        int unsigned delay;
        logic        x_we;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
        logic        x_f_ack;
        logic        x_e_ack;
        logic [31:0] x_rdata;
    } vec_t;

    vec_t vecs [6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drop_reqs();
        bus.i_f_req = 1'b0;
        bus.i_e_req = 1'b0;
        bus.i_e_we  = 1'b0;
    endtask

    task automatic do_ack(input logic [31:0] rd);
        bus.i_m_ack   = 1'b1;
        bus.i_m_rdata = rd;
        tick();
        bus.i_m_ack   = 1'b0;
        bus.i_m_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mreq"},  bus.o_m_req, 0);
        chk({tag, "_mwe"},   bus.o_m_we, 0);
        chk({tag, "_maddr"}, bus.o_m_addr, 0);
        chk({tag, "_mbe"},   bus.o_m_byte_en, 0);
        chk({tag, "_mwd"},   bus.o_m_wdata, 0);
        chk({tag, "_rdata"}, bus.o_rdata, 0);
        chk({tag, "_facks"}, {bus.o_f_ack, bus.o_e_ack}, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        bus.i_f_req     = v.f_req;
        bus.i_f_addr    = v.f_addr;
        bus.i_e_req     = v.e_req;
        bus.i_e_we      = v.e_we;
        bus.i_e_addr    = v.e_addr;
        bus.i_e_byte_en = v.be;
        bus.i_e_wdata   = v.wdata;
        tick();
        chk({t, "_mreq_rise"}, bus.o_m_req, 1);
        chk({t, "_mwe"},   bus.o_m_we, v.x_we);
        chk({t, "_maddr"}, bus.o_m_addr, v.x_addr);
        chk({t, "_mbe"},   bus.o_m_byte_en, v.x_be);
        if (v.x_we) chk({t, "_mwd"}, bus.o_m_wdata, v.x_wdata);
        chk({t, "_wait"},  bus.o_wait, v.e_req);
        for (int unsigned d = 0; d < v.delay; d++) begin
            tick();
            chk({t, "_mreq_hold"}, bus.o_m_req, 1);
            chk({t, "_noack_early"}, {bus.o_f_ack, bus.o_e_ack}, 0);
        end
        do_ack(v.m_rdata);
        chk({t, "_acks"},  {bus.o_f_ack, bus.o_e_ack}, {v.x_f_ack, v.x_e_ack});
        chk({t, "_rdata"}, bus.o_rdata, v.x_rdata);
        chk({t, "_mreq_drop"}, bus.o_m_req, 0);
        chk({t, "_wait_ack"}, bus.o_wait, 0);
        drop_reqs();
        tick();
        chk({t, "_ack_pulse"}, {bus.o_f_ack, bus.o_e_ack}, 0);
        chk({t, "_idle"}, bus.o_m_req, 0);
    endtask

    initial begin
        logic [31:0] seq_addr [4];
        logic        seq_e    [4];

        vecs[0] = '{1, 0, 0, 32'h100, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 3,
                    0, 32'h100, 4'hF, 32'h0, 1, 0, 32'hDEADBEEF};
        vecs[1] = '{0, 1, 1, 32'h0, 32'h2000, 4'b0011, 32'h1234, 32'h55555555, 2,
                    1, 32'h2000, 4'b0011, 32'h1234, 0, 1, 32'hDEADBEEF};
        vecs[2] = '{0, 1, 0, 32'h0, 32'h44, 4'hF, 32'h0, 32'hCAFEF00D, 0,
                    0, 32'h44, 4'hF, 32'h0, 0, 1, 32'hCAFEF00D};
`ifdef LSU_ARB_RR_EN
        // Execute won last, so the tie goes to fetch
        vecs[3] = '{1, 1, 0, 32'h300, 32'h400, 4'hF, 32'h0, 32'h0BADF00D, 1,
                    0, 32'h300, 4'hF, 32'h0, 1, 0, 32'h0BADF00D};
`else
        vecs[3] = '{1, 1, 0, 32'h300, 32'h400, 4'hF, 32'h0, 32'h0BADF00D, 1,
                    0, 32'h400, 4'hF, 32'h0, 0, 1, 32'h0BADF00D};
`endif
        vecs[4] = '{0, 1, 1, 32'h0, 32'h8, 4'hC, 32'hAABBCCDD, 32'hFFFFFFFF, 0,
                    1, 32'h8, 4'hC, 32'hAABBCCDD, 0, 1, 32'h0BADF00D};
        vecs[5] = '{1, 0, 0, 32'h1FC, 32'h0, 4'h0, 32'h0, 32'h12345678, 1,
                    0, 32'h1FC, 4'hF, 32'h0, 1, 0, 32'h12345678};

        clk_en = 1'b1;
        bus.i_m_ack = 1'b0;
        bus.i_m_rdata = '0;
        bus.i_f_addr = '0;
        bus.i_e_addr = '0;
        bus.i_e_byte_en = '0;
        bus.i_e_wdata = '0;
        drop_reqs();
        do_reset();
        chk_all_zero("reset");
        chk("reset_wait", bus.o_wait, 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Memory ack while idle must be ignored
        do_ack(32'h77777777);
        chk("idle_ack_noack", {bus.o_f_ack, bus.o_e_ack}, 0);
        chk("idle_ack_rdata", bus.o_rdata, 32'h12345678);
        chk("idle_ack_mreq", bus.o_m_req, 0);

        // Request raised and withdrawn while the clock enable is low is never granted
        clk_en = 1'b0;
        bus.i_f_req = 1'b1;
        bus.i_f_addr = 32'h900;
        tick();
        chk("wd_frozen", bus.o_m_req, 0);
        drop_reqs();
        clk_en = 1'b1;
        tick();
        chk("wd_dropped", bus.o_m_req, 0);
        tick();
        chk("wd_noack", {bus.o_f_ack, bus.o_e_ack}, 0);

        // Clock enable low for 5 cycles mid BUSY_E with an ack pulse inside
        bus.i_e_req = 1'b1;
        bus.i_e_we = 1'b0;
        bus.i_e_addr = 32'h80;
        bus.i_e_byte_en = 4'hF;
        tick();
        chk("ce_grant", bus.o_m_req, 1);
        clk_en = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) bus.i_m_ack = 1'b1;
            bus.i_m_rdata = 32'h99999999;
            tick();
            bus.i_m_ack = 1'b0;
            chk("ce_mreq", bus.o_m_req, 1);
            chk("ce_eack", bus.o_e_ack, 0);
            chk("ce_wait", bus.o_wait, 1);
            chk("ce_maddr", bus.o_m_addr, 32'h80);
        end
        clk_en = 1'b1;
        chk("ce_reenable_mreq", bus.o_m_req, 1);
        tick();
        chk("ce_still_busy", bus.o_m_req, 1);
        chk("ce_rdata_kept", bus.o_rdata, 32'h12345678);
        do_ack(32'hA5A5A5A5);
        chk("ce_ack", {bus.o_f_ack, bus.o_e_ack}, 2'b01);
        chk("ce_rdata", bus.o_rdata, 32'hA5A5A5A5);
        drop_reqs();
        tick();

        // Reset (with clock enable low) during BUSY_F, then a stray memory ack
        bus.i_f_req = 1'b1;
        bus.i_f_addr = 32'h700;
        tick();
        chk("rst_busy_mreq", bus.o_m_req, 1);
        clk_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clk_en = 1'b1;
        drop_reqs();
        chk_all_zero("rst_mid");
        do_ack(32'h31415926);
        chk_all_zero("rst_stray");
        tick();
        chk("rst_stray_late", {bus.o_f_ack, bus.o_e_ack}, 0);

        // Both requesters held for four back-to-back transactions
`ifdef LSU_ARB_RR_EN
        seq_e = '{1, 0, 1, 0};
`else
        seq_e = '{1, 1, 1, 1};
`endif
        for (int k = 0; k < 4; k++) seq_addr[k] = seq_e[k] ? 32'hE00 : 32'hF00;
        do_reset();
        bus.i_f_req = 1'b1;
        bus.i_f_addr = 32'hF00;
        bus.i_e_req = 1'b1;
        bus.i_e_we = 1'b0;
        bus.i_e_addr = 32'hE00;
        bus.i_e_byte_en = 4'hF;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d_mreq", k), bus.o_m_req, 1);
            chk($sformatf("rr%0d_addr", k), bus.o_m_addr, seq_addr[k]);
            do_ack(32'h1000 + k);
            chk($sformatf("rr%0d_acks", k), {bus.o_f_ack, bus.o_e_ack}, {!seq_e[k], seq_e[k]});
            chk($sformatf("rr%0d_rdata", k), bus.o_rdata, 32'h1000 + k);
            chk($sformatf("rr%0d_wait", k), bus.o_wait, !seq_e[k]);
            if (k == 3) drop_reqs();
            tick();
        end
        chk("rr_end_idle", bus.o_m_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 32, address width.
REQ-002 The block SHALL have parameter DW, default 32, data width.
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_clk_en  input  1  global clock enable; low = every register holds.
REQ-006 i_f_req  input  1  fetch read request, held until o_f_ack.
REQ-007 i_f_addr  input  AW  fetch read address.
REQ-008 o_f_ack  output  1  fetch completion pulse; o_rdata valid this cycle.
REQ-009 i_e_req  input  1  execute load/store request, held until o_e_ack.
REQ-010 i_e_we  input  1  execute request is a write when high.
REQ-011 i_e_addr  input  AW  execute address.
REQ-012 i_e_byte_en  input  DW/8  execute write byte enables.
REQ-013 i_e_wdata  input  DW  execute write data.
REQ-014 o_e_ack  output  1  execute completion pulse; o_rdata valid this cycle for reads.
REQ-015 o_rdata  output  DW  registered read data, shared by both requesters.
REQ-016 o_wait  output  1  to stall unit; execute request pending and not yet acked.
REQ-017 o_m_req  output  1  memory request, held until i_m_ack.
REQ-018 o_m_we, o_m_addr, o_m_byte_en, o_m_wdata  output  1/AW/DW/8/DW  registered memory command.
REQ-019 i_m_rdata  input  DW  memory read data, valid with i_m_ack.
REQ-020 i_m_ack  input  1  memory completion, one cycle.

Function
REQ-021 Work SHALL occur only in cycles with i_clk_en high; i_m_ack and requests are ignored otherwise.
REQ-022 FSM states SHALL be IDLE, BUSY_F, BUSY_E.
REQ-023 IDLE: if any request is high, the arbiter SHALL grant one, latch its command into the o_m_* registers, and enter BUSY_F or BUSY_E. With no request it SHALL remain in IDLE.
REQ-024 Fetch grant SHALL drive o_m_we=0 and o_m_byte_en=all ones.
REQ-025 o_m_req SHALL rise the cycle after the grant and stay high, with a stable command, until the cycle i_m_ack is sampled.
REQ-026 On i_m_ack in BUSY_x, the next cycle SHALL:
  - drop o_m_req;
  - capture i_m_rdata into o_rdata (reads only; writes leave o_rdata unchanged);
  - pulse o_x_ack for exactly one cycle;
  - return to IDLE.
REQ-027 Latency: request seen in IDLE at cycle N gives o_m_req at N+1. i_m_ack at cycle M gives ack at M+1. The next grant can occur at M+1, with o_m_req at M+2.
REQ-028 Withdrawal: a request withdrawn before grant SHALL be dropped silently. Once granted, a transaction SHALL complete regardless of the request level.
REQ-029 i_m_ack in IDLE SHALL be ignored.
REQ-030 o_wait SHALL equal i_e_req AND NOT o_e_ack (combinational).
REQ-031 Acks SHALL never be asserted simultaneously, and only one transaction SHALL be outstanding at a time.

Reset
REQ-032 i_rst SHALL force IDLE, all outputs 0 (o_rdata=0, o_m_*=0), and last-grant=fetch. It SHALL take effect regardless of i_clk_en.
REQ-033 Reset mid-transaction SHALL abandon it: no ack is issued, and a later i_m_ack is ignored.

Configuration
REQ-034 Macro LSU_ARB_RR_EN SHALL select the arbitration policy:
  - Defined: round robin. On simultaneous requests, grant the requester not granted last; update last-grant on every grant.
  - Undefined: fixed priority, execute over fetch; last-grant unused.

Verification
REQ-035 Fetch only, addr 0x100, i_m_ack 3 cycles after o_m_req, rdata 0xDEADBEEF -> o_m_addr=0x100, o_f_ack one cycle, o_rdata=0xDEADBEEF.
REQ-036 Execute write, addr 0x2000, byte_en 0b0011, wdata 0x1234 -> o_m_we=1 with those fields. o_e_ack pulses, o_rdata unchanged, o_wait high until the ack cycle.
REQ-037 Both requests held for 4 transactions -> without macro: E,E,E,E. With LSU_ARB_RR_EN: E,F,E,F.
REQ-038 i_clk_en low for 5 cycles mid-BUSY_E while i_m_ack pulses -> ack ignored, state and outputs frozen, o_m_req still high on re-enable.
REQ-039 i_rst asserted while BUSY_F, then i_m_ack -> IDLE, no o_f_ack, all outputs 0.
